// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the write-back / register-file slice:
// instruction codes, register ids, status encodings and the data width.
package y86_pkg;

  localparam int DATA_W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic [1:0] {
    S_AOK = 2'd0,
    S_HLT = 2'd1,
    S_ADR = 2'd2,
    S_INS = 2'd3
  } stat_t;

  // True when a register id addresses a real architectural register.
  function automatic logic reg_ok(input logic [3:0] id, input int nreg);
    return (int'({28'd0, id}) < nreg);
  endfunction

endpackage

// File: rtl/y86_regfile_2r2w.sv
// Register storage with two write ports (M port wins on address clash) and two
// combinational read ports; define REGFILE_BYPASS_EN to forward in-flight writes.
module y86_regfile_2r2w
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_e,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] data_e,
  input  logic              we_m,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] data_m,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs_r [NREG];
  logic              wr_e_s;
  logic              wr_m_s;

  // Out-of-range ids never write; a clash with the M port suppresses the E write.
  assign wr_m_s = we_m && reg_ok(dst_m, NREG);
  assign wr_e_s = we_e && reg_ok(dst_e, NREG) && !(wr_m_s && (dst_m == dst_e));

  // Storage array update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      if (wr_e_s) begin
        regs_r[dst_e] <= data_e;
      end
      if (wr_m_s) begin
        regs_r[dst_m] <= data_m;
      end
    end
  end

  // Read port A.
  always_comb begin
    rd_a = '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_m_s && (src_a == dst_m)) begin
      rd_a = data_m;
    end else if (wr_e_s && (src_a == dst_e)) begin
      rd_a = data_e;
    end else if (reg_ok(src_a, NREG)) begin
      rd_a = regs_r[src_a];
    end else begin
      rd_a = '0;
    end
`else
    if (reg_ok(src_a, NREG)) begin
      rd_a = regs_r[src_a];
    end else begin
      rd_a = '0;
    end
`endif
  end

  // Read port B.
  always_comb begin
    rd_b = '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_m_s && (src_b == dst_m)) begin
      rd_b = data_m;
    end else if (wr_e_s && (src_b == dst_e)) begin
      rd_b = data_e;
    end else if (reg_ok(src_b, NREG)) begin
      rd_b = regs_r[src_b];
    end else begin
      rd_b = '0;
    end
`else
    if (reg_ok(src_b, NREG)) begin
      rd_b = regs_r[src_b];
    end else begin
      rd_b = '0;
    end
`endif
  end

endmodule

// File: rtl/y86_writeback_regfile.sv
// Y86-64 write-back stage: destination decode, status FSM, retire counter and
// the register file. Optional same-cycle read forwarding via REGFILE_BYPASS_EN.
module y86_writeback_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [1:0]        stat_in,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA_rd,
  output logic [DATA_W-1:0] valB_rd,
  output logic [1:0]        stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  stat_t            stat_r;
  stat_t            next_stat_s;
  logic             halted_r;
  logic [CNT_W-1:0] retired_r;
  logic             commit_s;
  logic [3:0]       dst_e_s;
  logic [3:0]       dst_m_s;

  // Destination decode from the retiring instruction.
  always_comb begin
    dst_e_s = RNONE;
    dst_m_s = RNONE;
    case (icode)
      I_RRMOVQ: begin
        if (cnd) begin
          dst_e_s = rB;
        end else begin
          dst_e_s = RNONE;
        end
      end
      I_IRMOVQ, I_OPQ:         dst_e_s = rB;
      I_CALL, I_RET, I_PUSHQ:  dst_e_s = RSP;
      I_MRMOVQ:                dst_m_s = rA;
      I_POPQ: begin
        dst_e_s = RSP;
        dst_m_s = rA;
      end
      default: begin
        dst_e_s = RNONE;
        dst_m_s = RNONE;
      end
    endcase
  end

  // Status next-state and commit qualification; non-AOK states hold until reset.
  always_comb begin
    next_stat_s = stat_r;
    commit_s    = 1'b0;
    case (stat_r)
      S_AOK: begin
        if (wb_valid) begin
          if (stat_in != 2'd0) begin
            next_stat_s = stat_t'(stat_in);
          end else if (icode == I_HALT) begin
            next_stat_s = S_HLT;
          end else begin
            commit_s = 1'b1;
          end
        end else begin
          next_stat_s = S_AOK;
        end
      end
      default: begin
        next_stat_s = stat_r;
        commit_s    = 1'b0;
      end
    endcase
  end

  // Status, halted flag and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_r    <= S_AOK;
      halted_r  <= 1'b0;
      retired_r <= '0;
    end else begin
      stat_r   <= next_stat_s;
      halted_r <= (next_stat_s != S_AOK);
      if (commit_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign stat    = stat_r;
  assign halted  = halted_r;
  assign retired = retired_r;

  y86_regfile_2r2w #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_e   (commit_s && (dst_e_s != RNONE)),
    .dst_e  (dst_e_s),
    .data_e (valE),
    .we_m   (commit_s && (dst_m_s != RNONE)),
    .dst_m  (dst_m_s),
    .data_m (valM),
    .src_a  (srcA),
    .src_b  (srcB),
    .rd_a   (valA_rd),
    .rd_b   (valB_rd)
  );

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized retirement traffic against an architectural register-file model.
module tb_y86_writeback_regfile;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0;
  logic [3:0]  rA = 4'hF;
  logic [3:0]  rB = 4'hF;
  logic [63:0] valE = 64'd0;
  logic [63:0] valM = 64'd0;
  logic [1:0]  stat_in = 2'd0;
  logic [3:0]  srcA = 4'hF;
  logic [3:0]  srcB = 4'hF;
  logic [63:0] valA_rd;
  logic [63:0] valB_rd;
  logic [1:0]  stat;
  logic        halted;
  logic [CW-1:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m_reg [15];
  int          m_stat;
  int          m_ret;

  always #50 clk = ~clk;

  y86_writeback_regfile #(.DATA_W(64), .NREG(15), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode), .cnd(cnd),
    .rA(rA), .rB(rB), .valE(valE), .valM(valM), .stat_in(stat_in),
    .srcA(srcA), .srcB(srcB), .valA_rd(valA_rd), .valB_rd(valB_rd),
    .stat(stat), .halted(halted), .retired(retired)
  );

  typedef struct {
    logic [3:0]  ic;
    logic        c;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] ve;
    logic [63:0] vm;
    logic [3:0]  reg_id;
    logic [63:0] exp_val;
    int          exp_ret;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural effect of one retirement slot, straight from the ISA rules.
  task automatic model_apply(input logic v, input logic [3:0] ic, input logic c,
                             input logic [3:0] ra, input logic [3:0] rb,
                             input logic [63:0] ve, input logic [63:0] vm,
                             input logic [1:0] si);
    int de, dm;
    if (v && m_stat == 0) begin
      if (si != 2'd0) m_stat = int'(si);
      else if (ic == 4'h0) m_stat = 1;
      else begin
        de = 15; dm = 15;
        if (ic == 4'h6 || ic == 4'h3 || (ic == 4'h2 && c)) de = int'(rb);
        if (ic >= 4'h8 && ic <= 4'hB) de = 4;
        if (ic == 4'h5 || ic == 4'hB) dm = int'(ra);
        if (de < 15) m_reg[de] = ve;
        if (dm < 15) m_reg[dm] = vm;
        m_ret = (m_ret + 1) % (1 << CW);
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
    m_stat = 0;
    m_ret  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_valid = 1'b0;
    rst_n = 1'b0;
    #5;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic step(input logic v, input logic [3:0] ic, input logic c,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] ve, input logic [63:0] vm, input logic [1:0] si);
    @(negedge clk);
    wb_valid = v; icode = ic; cnd = c; rA = ra; rB = rb;
    valE = ve; valM = vm; stat_in = si;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    model_apply(v, ic, c, ra, rb, ve, vm, si);
  endtask

  task automatic check_all();
    for (int i = 0; i < 15; i++) begin
      srcA = 4'(i);
      srcB = 4'(14 - i);
      #1;
      chk($sformatf("valA_rd[R%0d]", i), valA_rd, m_reg[i]);
      chk($sformatf("valB_rd[R%0d]", 14 - i), valB_rd, m_reg[14 - i]);
    end
    srcA = 4'hF; srcB = 4'hF;
    #1;
    chk("valA_rd[RNONE]", valA_rd, 64'd0);
    chk("valB_rd[RNONE]", valB_rd, 64'd0);
    chk("stat", {62'd0, stat}, 64'(m_stat));
    chk("halted", {63'd0, halted}, (m_stat != 0) ? 64'd1 : 64'd0);
    chk("retired", {60'd0, retired}, 64'(m_ret));
  endtask

  initial begin
    vecs[0]  = '{4'h3, 1'b0, 4'hF, 4'h3, 64'h1234, 64'h0,  4'h3, 64'h1234, 1};
    vecs[1]  = '{4'h2, 1'b0, 4'h1, 4'h2, 64'h5,    64'h0,  4'h2, 64'h0,    2};
    vecs[2]  = '{4'h2, 1'b1, 4'h1, 4'h2, 64'h5,    64'h0,  4'h2, 64'h5,    3};
    vecs[3]  = '{4'hB, 1'b0, 4'h4, 4'hF, 64'h108,  64'hAA, 4'h4, 64'hAA,   4};
    vecs[4]  = '{4'hA, 1'b0, 4'h1, 4'hF, 64'hF8,   64'h0,  4'h4, 64'hF8,   5};
    vecs[5]  = '{4'h5, 1'b0, 4'h9, 4'h1, 64'h77,   64'h55, 4'h9, 64'h55,   6};
    vecs[6]  = '{4'h3, 1'b0, 4'hF, 4'hF, 64'hDEAD, 64'h0,  4'h3, 64'h1234, 7};
    vecs[7]  = '{4'h6, 1'b0, 4'h1, 4'h3, 64'h99,   64'h0,  4'h3, 64'h99,   8};
    vecs[8]  = '{4'h1, 1'b0, 4'h5, 4'h5, 64'h11,   64'h22, 4'h5, 64'h0,    9};
    vecs[9]  = '{4'hB, 1'b0, 4'h6, 4'hF, 64'h200,  64'h33, 4'h6, 64'h33,   10};
    vecs[10] = '{4'h8, 1'b0, 4'hF, 4'hF, 64'h1F0,  64'h0,  4'h4, 64'h1F0,  11};

    model_clear();
    do_reset();
    check_all();

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, vecs[i].ic, vecs[i].c, vecs[i].ra, vecs[i].rb, vecs[i].ve, vecs[i].vm, 2'd0);
      srcA = vecs[i].reg_id;
      #1;
      chk($sformatf("vec%0d reg", i), valA_rd, vecs[i].exp_val);
      chk($sformatf("vec%0d retired", i), {60'd0, retired}, 64'(vecs[i].exp_ret % (1 << CW)));
      check_all();
    end

    // Halt: status latches, nothing retires, later instructions are ignored.
    step(1'b1, 4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 2'd0);
    chk("halt stat", {62'd0, stat}, 64'd1);
    chk("halt halted", {63'd0, halted}, 64'd1);
    chk("halt retired", {60'd0, retired}, 64'd11);
    step(1'b1, 4'h3, 1'b0, 4'hF, 4'h3, 64'hBAD, 64'h0, 2'd0);
    srcA = 4'h3;
    #1;
    chk("post-halt R3", valA_rd, 64'h99);
    chk("post-halt retired", {60'd0, retired}, 64'd11);
    check_all();

    // Upstream address fault on a register-writing instruction.
    do_reset();
    step(1'b1, 4'h3, 1'b0, 4'hF, 4'h3, 64'h77, 64'h0, 2'd2);
    srcA = 4'h3;
    #1;
    chk("adr stat", {62'd0, stat}, 64'd2);
    chk("adr R3", valA_rd, 64'd0);
    chk("adr retired", {60'd0, retired}, 64'd0);
    check_all();

    // Same-cycle read of an in-flight write.
    do_reset();
    @(negedge clk);
    wb_valid = 1'b1; icode = 4'h3; cnd = 1'b0; rA = 4'hF; rB = 4'h7;
    valE = 64'h9; valM = 64'h0; stat_in = 2'd0; srcA = 4'h7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass valA_rd", valA_rd, 64'h9);
`else
    chk("bypass valA_rd", valA_rd, 64'h0);
`endif
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    model_apply(1'b1, 4'h3, 1'b0, 4'hF, 4'h7, 64'h9, 64'h0, 2'd0);
    check_all();

    // Asynchronous reset in the middle of a cycle with wb_valid high.
    step(1'b1, 4'h3, 1'b0, 4'hF, 4'h8, 64'h5A5A, 64'h0, 2'd0);
    @(negedge clk);
    wb_valid = 1'b1; icode = 4'h1; srcA = 4'h8;
    #10;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("async rst R8", valA_rd, 64'd0);
    chk("async rst retired", {60'd0, retired}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst held retired", {60'd0, retired}, 64'd0);
    wb_valid = 1'b0;
    rst_n = 1'b1;
    check_all();

    // Randomized retirement traffic, including counter wrap and faults.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_stat != 0 && $urandom_range(0, 2) == 0) begin
        do_reset();
      end else begin
        logic v;
        logic [3:0] ic;
        logic [1:0] si;
        v  = ($urandom_range(0, 7) != 0);
        ic = ($urandom_range(0, 39) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        si = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        step(v, ic, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}, si);
      end
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
